count_range_monitor: RTL

- Downstream checker for the free-running range counter (LO..HI, wrap HI->LO) that drives a 32-bit `count` bus.
- Each enabled cycle it samples `count` and emits a one-cycle pulse for every legal wrap.
- It keeps a saturating wrap tally and latches a sticky fault on any out-of-range value or illegal step.
- Outputs feed status/debug logic and the test-bench scoreboard.

---
 rtl/count_range_monitor.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/count_range_monitor.sv
// count_range_monitor
//   Downstream checker for a free-running range counter that counts
//   LO..HI and wraps HI->LO. Every enabled cycle the count bus is sampled;
//   a legal wrap produces a one-cycle pulse and bumps a saturating tally.
//   Any out-of-range value or illegal step latches a sticky fault that holds
//   until clr or rst.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous reset, active-high (highest priority)
//   en          sample valid: count_in is evaluated only when en=1
//   clr         synchronous clear of statistics and fault, back to INIT
//   count_in    count value from the upstream counter (unsigned)
//   wrap_pulse  one-cycle pulse per legal HI->LO wrap
//   wrap_cnt    saturating number of legal wraps
//   wrap_sat    sticky, set when a wrap arrives while wrap_cnt is all-ones
//   fault       sticky fault flag
//   fault_code  01 out-of-range, 10 bad step, 00 none
//   fault_val   count_in value that caused the first fault
//   state       00 INIT, 01 TRACK, 10 FAULT
//
// Handshake: en is a plain sample-valid qualifier with no back-pressure;
// the monitor accepts a sample on every rising edge where en=1 and it is
// not in FAULT. All outputs are registered, so a sample's effect appears
// one cycle after the edge that captured it.

module count_range_monitor #(
    parameter int CNT_W  = 32,
    parameter int LO     = 18,
    parameter int HI     = 27,
    parameter int WRAP_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [CNT_W-1:0]  count_in,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              wrap_sat,
    output logic              fault,
    output logic [1:0]        fault_code,
    output logic [CNT_W-1:0]  fault_val,
    output logic [1:0]        state
);

    generate
        if (LO >= HI) begin : g_bad_range
            $error("count_range_monitor: LO must be strictly below HI");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_INIT  = 2'b00,
        ST_TRACK = 2'b01,
        ST_FAULT = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] LO_V = CNT_W'(LO);
    localparam logic [CNT_W-1:0] HI_V = CNT_W'(HI);

    localparam logic [1:0] CODE_RANGE = 2'b01;
    localparam logic [1:0] CODE_STEP  = 2'b10;

    state_t           cur_state;
    logic [CNT_W-1:0] prev;

    // One bit wider than the bus so prev+1 never aliases back to zero.
    logic [CNT_W:0]   prev_inc;
    logic             in_range;
    logic             is_step;

    assign prev_inc = {1'b0, prev} + 1'b1;
    assign in_range = (count_in >= LO_V) && (count_in <= HI_V);
    assign is_step  = (prev < HI_V) && ({1'b0, count_in} == prev_inc);

    assign state = cur_state;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cur_state  <= ST_INIT;
            prev       <= '0;
            wrap_pulse <= 1'b0;
            wrap_cnt   <= '0;
            wrap_sat   <= 1'b0;
            fault      <= 1'b0;
            fault_code <= 2'b00;
            fault_val  <= '0;
        end else begin
            // Pulse defaults low; only a legal wrap below raises it.
            wrap_pulse <= 1'b0;
            if (en) begin
                case (cur_state)
                    ST_INIT: begin
                        if (in_range) begin
                            // First sample only seeds prev; it never wraps.
                            prev      <= count_in;
                            cur_state <= ST_TRACK;
                        end else begin
                            fault      <= 1'b1;
                            fault_code <= CODE_RANGE;
                            fault_val  <= count_in;
                            cur_state  <= ST_FAULT;
                        end
                    end
                    ST_TRACK: begin
                        if (!in_range) begin
                            fault      <= 1'b1;
                            fault_code <= CODE_RANGE;
                            fault_val  <= count_in;
                            cur_state  <= ST_FAULT;
                        end else if ((prev == HI_V) && (count_in == LO_V)) begin
                            wrap_pulse <= 1'b1;
                            prev       <= LO_V;
                            if (wrap_cnt == '1) begin
                                wrap_sat <= 1'b1;
                            end else begin
                                wrap_cnt <= wrap_cnt + 1'b1;
                            end
                        end else if (is_step) begin
                            prev <= count_in;
                        end else if (count_in == prev) begin
                            // Upstream stalled: legal hold, nothing changes.
                            prev <= prev;
                        end else begin
                            fault      <= 1'b1;
                            fault_code <= CODE_STEP;
                            fault_val  <= count_in;
                            cur_state  <= ST_FAULT;
                        end
                    end
                    default: begin
                        // FAULT: frozen until clr or rst.
                        cur_state <= cur_state;
                    end
                endcase
            end
        end
    end

endmodule
